alu_wide_sequencer: RTL

Multi-cycle driver for the 8-bit datapath ALU. It performs 16-bit add, sub, and, or operations by issuing byte-wide passes to the ALU. It drives the ALU's a, b and ALUControl inputs. It consumes the ALU's y, overflow (used as carry/borrow) and BranchFlag (used as zero) outputs. It sits between the control unit and the ALU for wide-operand instructions, with a start/busy/done handshake.

---
 rtl/alu_wide_sequencer_if.sv | 33 +++
 rtl/alu_wide_sequencer.sv | 122 ++++++++++++
 2 files changed

// File: rtl/alu_wide_sequencer_if.sv
`default_nettype none
// ============================================================================
// alu_wide_sequencer_if : request/result handshake plus 8-bit ALU drive bus
// Revision 1.0
// ============================================================================
interface alu_wide_sequencer_if;
  logic        start;
  logic [1:0]  op;
  logic [15:0] opa;
  logic [15:0] opb;
  logic [15:0] result;
  logic        carry_out;
  logic        zero;
  logic        busy;
  logic        done;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [2:0]  alu_ctl;
  logic [7:0]  alu_y;
  logic        alu_ovf;
  logic        alu_zero;

  modport slave (
    input  start, op, opa, opb, alu_y, alu_ovf, alu_zero,
    output result, carry_out, zero, busy, done, alu_a, alu_b, alu_ctl
  );

  modport master (
    output start, op, opa, opb, alu_y, alu_ovf, alu_zero,
    input  result, carry_out, zero, busy, done, alu_a, alu_b, alu_ctl
  );
endinterface
`default_nettype wire

// File: rtl/alu_wide_sequencer.sv
`default_nettype none
// ============================================================================
// alu_wide_sequencer : 16-bit add/sub/and/or built from byte-wide ALU passes
// Revision 1.0
// ============================================================================
module alu_wide_sequencer (
  input  wire logic             clk,
  input  wire logic             reset,
  alu_wide_sequencer_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LO   = 3'd1,
    S_HI   = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic [1:0]  r_op;
  logic [15:0] r_result;
  logic        r_c0;
  logic        r_c1;
  logic        r_z0;
  logic        r_carry;
  logic        r_zero;
  logic [7:0]  w_alu_a;
  logic [7:0]  w_alu_b;
  logic [2:0]  w_alu_ctl;

  always_comb begin
    w_next    = r_state;
    w_alu_a   = 8'h00;
    w_alu_b   = 8'h00;
    w_alu_ctl = 3'b000;
    case (r_state)
      S_IDLE: if (bus.start) w_next = S_LO;
      S_LO: begin
        w_alu_a   = r_a[7:0];
        w_alu_b   = r_b[7:0];
        w_alu_ctl = {1'b0, r_op};
        w_next    = S_HI;
      end
      S_HI: begin
        w_alu_a   = r_a[15:8];
        w_alu_b   = r_b[15:8];
        w_alu_ctl = {1'b0, r_op};
        w_next    = r_op[1] ? S_DONE : S_FIX;
      end
      // Propagate the low-byte carry/borrow into the high byte.
      S_FIX: begin
        w_alu_a   = r_result[15:8];
        w_alu_b   = {7'b0, r_c0};
        w_alu_ctl = {2'b00, r_op[0]};
        w_next    = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_a      <= 16'h0000;
      r_b      <= 16'h0000;
      r_op     <= 2'b00;
      r_result <= 16'h0000;
      r_c0     <= 1'b0;
      r_c1     <= 1'b0;
      r_z0     <= 1'b0;
      r_carry  <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_a  <= bus.opa;
            r_b  <= bus.opb;
            r_op <= bus.op;
          end
        end
        S_LO: begin
          r_result[7:0] <= bus.alu_y;
          r_c0          <= bus.alu_ovf;
          r_z0          <= bus.alu_zero;
        end
        // Flags are settled on the edge entering DONE so they are valid with done.
        S_HI: begin
          r_result[15:8] <= bus.alu_y;
          r_c1           <= bus.alu_ovf;
          if (r_op[1]) begin
            r_carry <= 1'b0;
            r_zero  <= r_z0 & bus.alu_zero;
          end
        end
        S_FIX: begin
          r_result[15:8] <= bus.alu_y;
          r_carry        <= r_c1 | bus.alu_ovf;
          r_zero         <= r_z0 & bus.alu_zero;
        end
        default: ;
      endcase
    end
  end

  assign bus.alu_a     = w_alu_a;
  assign bus.alu_b     = w_alu_b;
  assign bus.alu_ctl   = w_alu_ctl;
  assign bus.result    = r_result;
  assign bus.carry_out = r_carry;
  assign bus.zero      = r_zero;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = (r_state == S_DONE);

endmodule
`default_nettype wire
